// File: rtl/clk_freq_meter_pkg.sv
// Shared definitions for the clock frequency meter: FSM encoding and
// default timing constants for a 50 MHz clk_in.
package clk_freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GATE = 2'd2,
    ST_DONE = 2'd3
  } meas_state_e;

  localparam int unsigned DEF_GATE_CYCLES = 32'd5_000_000;
  localparam int unsigned DEF_ARM_TIMEOUT = 32'd5_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_freq_meter_sync_edge_det.sv
// Two-flop synchroniser followed by a rising-edge detector; the pulse is
// sampled by downstream logic on the third clk_i edge after d_i rises.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic pulse_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/clk_freq_meter.sv
// Gated edge counter measuring an asynchronous clock against clk_in, with
// a single shared timer for arm timeout and gate window, and valid/ack result hand-off.
module clk_freq_meter
  import clk_freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned ARM_TIMEOUT = DEF_ARM_TIMEOUT,
  parameter int unsigned CNT_W       = 24
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             meas_in,
  input  logic             start,
  input  logic             cont,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             no_sig
);

  localparam int unsigned TMR_W = $clog2(max_u(GATE_CYCLES, ARM_TIMEOUT) + 1);
  localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] ARM_LAST  = TMR_W'(ARM_TIMEOUT - 1);

  logic edge_pls;

  sync_edge_det u_sync_edge_det (
    .clk_i   (clk_in),
    .rst_ni  (reset),
    .d_i     (meas_in),
    .pulse_o (edge_pls)
  );

  meas_state_e      state_q,  state_d;
  logic [TMR_W-1:0] timer_q,  timer_d;
  logic [CNT_W-1:0] edges_q,  edges_d;
  logic             sat_q,    sat_d;
  logic             nosig_q,  nosig_d;
  logic             busy_q,   busy_d;
  logic             valid_q,  valid_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;
  logic             no_sig_q, no_sig_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    edges_d  = edges_q;
    sat_d    = sat_q;
    nosig_d  = nosig_q;
    valid_d  = valid_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    no_sig_d = no_sig_q;

    if (ack && valid_q) valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARM;
          timer_d = '0;
        end
      end
      ST_ARM: begin
        // The arming edge only opens the window; it is not itself counted.
        if (edge_pls) begin
          state_d = ST_GATE;
          timer_d = '0;
          edges_d = '0;
          sat_d   = 1'b0;
          nosig_d = 1'b0;
        end else if (timer_q == ARM_LAST) begin
          state_d = ST_DONE;
          edges_d = '0;
          sat_d   = 1'b0;
          nosig_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_GATE: begin
        if (edge_pls) begin
          if (edges_q == '1) sat_d = 1'b1;
          else               edges_d = edges_q + CNT_W'(1);
        end
        if (timer_q == GATE_LAST) state_d = ST_DONE;
        else                      timer_d = timer_q + TMR_W'(1);
      end
      ST_DONE: begin
        // Load overrides a coincident ack so a fresh result is never lost.
        count_d  = edges_q;
        ovf_d    = sat_q;
        no_sig_d = nosig_q;
        valid_d  = 1'b1;
        timer_d  = '0;
        state_d  = cont ? ST_ARM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_ARM) || (state_d == ST_GATE);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      edges_q  <= '0;
      sat_q    <= 1'b0;
      nosig_q  <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      no_sig_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      edges_q  <= edges_d;
      sat_q    <= sat_d;
      nosig_q  <= nosig_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      no_sig_q <= no_sig_d;
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign count  = count_q;
  assign ovf    = ovf_q;
  assign no_sig = no_sig_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter: a 24-bit and a 4-bit instance share all
// inputs; meas_in is generated with a period given in clk_in cycles.
module tb_clk_freq_meter;

  logic        clk_in;
  logic        reset;
  logic        meas_in;
  logic        start;
  logic        cont;
  logic        ack;
  logic        busy,  busy4;
  logic        valid, valid4;
  logic [23:0] count;
  logic [3:0]  count4;
  logic        ovf,   ovf4;
  logic        no_sig, no_sig4;

  int unsigned meas_period;
  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned n;

  clk_freq_meter #(.GATE_CYCLES(1000), .ARM_TIMEOUT(200), .CNT_W(24)) u_dut (
    .clk_in (clk_in), .reset (reset), .meas_in (meas_in), .start (start),
    .cont (cont), .ack (ack), .busy (busy), .valid (valid), .count (count),
    .ovf (ovf), .no_sig (no_sig)
  );

  clk_freq_meter #(.GATE_CYCLES(1000), .ARM_TIMEOUT(200), .CNT_W(4)) u_dut4 (
    .clk_in (clk_in), .reset (reset), .meas_in (meas_in), .start (start),
    .cont (cont), .ack (ack), .busy (busy4), .valid (valid4), .count (count4),
    .ovf (ovf4), .no_sig (no_sig4)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Asynchronous phase offset relative to clk_in.
  initial begin
    meas_in = 1'b0;
    #3;
    forever begin
      if (meas_period == 0) begin
        meas_in = 1'b0;
        #10;
      end else begin
        meas_in = 1'b1;
        #(meas_period * 5);
        meas_in = 1'b0;
        #(meas_period * 5);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs,
                         input logic [31:0] lo, input logic [31:0] hi);
    n_cmp++;
    assert (((obs >= lo) && (obs <= hi)) === 1'b1)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_valid(input string tag, input int unsigned budget);
    int unsigned k;
    k = 0;
    while (!valid && k < budget) begin
      @(negedge clk_in);
      k++;
    end
    chk(tag, {31'd0, valid}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk_in);
    ack = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    start = 1'b0;
    cont  = 1'b0;
    ack   = 1'b0;
    meas_period = 0;

    #23;
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_valid",  {31'd0, valid},  32'd0);
    chk("rst_count",  {8'd0, count},   32'd0);
    chk("rst_ovf",    {31'd0, ovf},    32'd0);
    chk("rst_no_sig", {31'd0, no_sig}, 32'd0);
    @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);

    // Period 10 -> 100 edges in 1000 cycles.
    meas_period = 10;
    repeat (5) @(negedge clk_in);
    pulse_start();
    chk("t1_busy_after_start", {31'd0, busy}, 32'd1);
    wait_valid("t1_valid_timeout", 3000);
    chk_rng("t1_count", {8'd0, count}, 32'd99, 32'd101);
    chk("t1_ovf",    {31'd0, ovf},    32'd0);
    chk("t1_no_sig", {31'd0, no_sig}, 32'd0);
    chk("t1_busy_done", {31'd0, busy}, 32'd0);
    pulse_ack();
    chk("t1_valid_cleared", {31'd0, valid}, 32'd0);

    // No signal: arm timeout of 200 cycles.
    meas_period = 0;
    repeat (10) @(negedge clk_in);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    n = 1;
    while (!valid && n < 400) begin
      @(negedge clk_in);
      n++;
    end
    chk_rng("t2_latency", n, 32'd199, 32'd204);
    chk("t2_count",  {8'd0, count},   32'd0);
    chk("t2_no_sig", {31'd0, no_sig}, 32'd1);
    chk("t2_ovf",    {31'd0, ovf},    32'd0);
    chk("t2_busy",   {31'd0, busy},   32'd0);
    pulse_ack();

    // Period 4 -> 250 edges; the 4-bit instance saturates.
    meas_period = 4;
    repeat (10) @(negedge clk_in);
    pulse_start();
    wait_valid("t3_valid_timeout", 3000);
    chk("t3_count4", {28'd0, count4}, 32'd15);
    chk("t3_ovf4",   {31'd0, ovf4},   32'd1);
    chk("t3_valid4", {31'd0, valid4}, 32'd1);
    chk_rng("t3_count24", {8'd0, count}, 32'd249, 32'd251);
    chk("t3_ovf24",  {31'd0, ovf},    32'd0);

    // Reset mid-gate with a previous result still pending.
    meas_period = 10;
    repeat (10) @(negedge clk_in);
    pulse_start();
    repeat (300) @(negedge clk_in);
    #2 reset = 1'b0;
    #1;
    chk("t5_busy",   {31'd0, busy},   32'd0);
    chk("t5_valid",  {31'd0, valid},  32'd0);
    chk("t5_count",  {8'd0, count},   32'd0);
    chk("t5_count4", {28'd0, count4}, 32'd0);
    chk("t5_ovf4",   {31'd0, ovf4},   32'd0);
    @(negedge clk_in);
    reset = 1'b1;
    repeat (20) @(negedge clk_in);
    chk("t5_no_partial", {31'd0, valid}, 32'd0);
    pulse_start();
    wait_valid("t5_valid_timeout", 3000);
    chk_rng("t5_count_after", {8'd0, count}, 32'd99, 32'd101);

    // Ack handling and start ignored during gate.
    pulse_ack();
    chk("t4_ack_clears", {31'd0, valid}, 32'd0);
    pulse_ack();
    chk("t4_ack_idle_valid", {31'd0, valid}, 32'd0);
    chk("t4_ack_idle_busy",  {31'd0, busy},  32'd0);
    pulse_start();
    n = 1;
    repeat (500) begin
      @(negedge clk_in);
      n++;
    end
    pulse_start();
    n++;
    while (!valid && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    chk_rng("t4_start_ignored_len", n, 32'd1001, 32'd1025);
    chk_rng("t4_count", {8'd0, count}, 32'd99, 32'd101);

    // Ack coincident with result load: start at cycle 0, DONE after edge 200.
    meas_period = 0;
    repeat (10) @(negedge clk_in);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    n = 1;
    while (n < 201) begin
      @(negedge clk_in);
      n++;
    end
    ack = 1'b1;
    @(negedge clk_in);
    ack = 1'b0;
    chk("t4_load_wins_valid", {31'd0, valid},  32'd1);
    chk("t4_load_wins_nosig", {31'd0, no_sig}, 32'd1);
    @(negedge clk_in);
    chk("t4_valid_held", {31'd0, valid}, 32'd1);
    pulse_ack();

    // Continuous mode.
    cont = 1'b1;
    meas_period = 8;
    repeat (10) @(negedge clk_in);
    pulse_start();
    wait_valid("t6_valid1_timeout", 3000);
    chk_rng("t6_count1", {8'd0, count}, 32'd124, 32'd126);
    chk("t6_rearm_busy", {31'd0, busy}, 32'd1);
    pulse_ack();
    wait_valid("t6_valid2_timeout", 3000);
    chk_rng("t6_count2", {8'd0, count}, 32'd124, 32'd126);
    meas_period = 5;
    repeat (2100) @(negedge clk_in);
    chk_rng("t6_overwrite", {8'd0, count}, 32'd199, 32'd201);
    chk("t6_valid_sticky", {31'd0, valid}, 32'd1);
    cont = 1'b0;
    n = 0;
    while (busy && n < 2100) begin
      @(negedge clk_in);
      n++;
    end
    chk("t6_stop_busy", {31'd0, busy}, 32'd0);
    chk_rng("t6_last_count", {8'd0, count}, 32'd199, 32'd201);
    repeat (1200) @(negedge clk_in);
    chk("t6_stays_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
